mux_2to1: RTL and testbench
===========================

Name:
mux_2to1

Overview:
- Parameterizable 2:1 data multiplexer: selects operand `a` when `sel`=0 and operand `b` when `sel`=1.
- Default build registers the output with one cycle of latency. A combinational mode is available.
- Includes a load enable, an output-valid flag and a saturating counter of select changes for debug.
- Used as a basic datapath steering element wherever one of two sources drives a downstream consumer.

Parameters:
- WIDTH, 1: bit width of `a`, `b` and `y`.
- REG_OUT, 1: 1 = `y` and `y_valid` registered (1-cycle latency); 0 = `y` and `y_valid` combinational.
- CNT_W, 8: width of `sel_changes` (the select-change counter).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  load enable; a selection is taken only when en=1.
- a  input  WIDTH  operand routed to `y` when sel=0.
- b  input  WIDTH  operand routed to `y` when sel=1.
- sel  input  1  select: 0 chooses `a`, 1 chooses `b`.
- y  output  WIDTH  selected data.
- y_valid  output  1  `y` holds data from an enabled selection this cycle.
- sel_changes  output  CNT_W  saturating count of enabled selections whose `sel` differed from the previous enabled `sel`.

Behaviour:
- Selection function: `y` = (sel ? b : a), bitwise across all WIDTH bits.

REG_OUT=1 (registered mode):
- Reset:
  - rst=1 at a rising edge sets y=0, y_valid=0, sel_changes=0, and the internal last-select register=0.
  - rst has priority over en.
- Enabled cycle: en=1 and rst=0 at edge N gives y = (sel ? b : a), sampled at edge N, visible after edge N; y_valid=1 after edge N.
- Disabled cycle: en=0 and rst=0 at an edge leaves `y` holding its last value; y_valid=0 after that edge.
- Back-to-back enables: a new selection every cycle, full throughput. `y` is never stale by more than one cycle.
- Inputs changing between edges have no effect on `y` until the next enabled edge.

REG_OUT=0 (combinational mode):
- y = (sel ? b : a) at all times, independent of clk, rst and en.
- y_valid = en & ~rst, combinational.
- `sel_changes` logic below is unchanged and stays registered.

Select-change counter (both modes):
- Internal register sel_last (1 bit), reset value 0.
- At an edge with rst=0 and en=1:
  - if sel != sel_last, increment `sel_changes` by 1, saturating at 2^CNT_W−1 (it never wraps);
  - sel_last <= sel.
- At an edge with en=0: counter and sel_last both hold.
- The first enabled cycle after reset with sel=1 counts as a change, because sel_last resets to 0.

Boundary conditions:
- Reset mid-stream: the next edge forces the reset values regardless of en, sel or data. The first post-reset enabled edge behaves like a fresh start.
- Counter at maximum with a further change: the counter stays at maximum; sel_last still updates.
- WIDTH=1 must be supported; no upper limit beyond tool limits.
- No X-propagation guarding: an unknown `sel` is an illegal stimulus.

Test Plan:
- Reset check: rst=1 for 2 cycles with en=1, a=1, b=0, sel=1 → y=0, y_valid=0, sel_changes=0 after each edge.
- Truth table, WIDTH=1, REG_OUT=1, en=1, one step per cycle, `y` checked the cycle after each step:
  - (a=0, b=1, sel=0) → y=0
  - (0, 1, 1) → y=1
  - (1, 0, 0) → y=1
  - (1, 0, 1) → y=0
  - y_valid=1 throughout; sel_changes=3 after the four steps.
- Hold: after selecting a=1 (sel=0), drop en, then change to a=0, b=1, sel=1 for 3 cycles → y stays 1, y_valid=0, sel_changes unchanged.
- Saturation: CNT_W=2, toggle sel with en=1 for 6 cycles starting at sel=1 → sel_changes sequence 1, 2, 3, 3, 3, 3.
- Wide/combinational: WIDTH=8, REG_OUT=0, a=0x5A, b=0xC3:
  - sel=0 → y=0x5A immediately; sel=1 → y=0xC3 immediately;
  - rst=1 does not alter `y`, but y_valid=0.
- Reset mid-operation: REG_OUT=1, running selections with sel_changes=2, assert rst for one edge → y=0, sel_changes=0. Next enabled edge with sel=1, b=1 → y=1, sel_changes=1.

Source files
------------

// File: rtl/mux_2to1.sv
// rtl/mux_2to1.sv - 2:1 data mux with optional output register, valid flag and select-change counter
module mux_2to1 #(
   parameter int WIDTH   = 1,
   parameter int REG_OUT = 1,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] y,
   output logic             y_valid,
   output logic [CNT_W-1:0] sel_changes
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] w_sel_data;
   logic             w_sel_changed;
   logic             r_sel_last;
   logic [CNT_W-1:0] r_sel_changes;

   assign w_sel_data    = sel ? b : a;
   assign w_sel_changed = (sel != r_sel_last);

   // Counter saturates rather than wrapping; sel_last tracks every enabled select.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel_last    <= 1'b0;
         r_sel_changes <= '0;
      end else if (en) begin
         r_sel_last <= sel;
         if (w_sel_changed && (r_sel_changes != CNT_MAX)) begin
            r_sel_changes <= r_sel_changes + CNT_W'(1);
         end
      end
   end

   assign sel_changes = r_sel_changes;

   generate
      if (REG_OUT != 0) begin : g_reg_out
         logic [WIDTH-1:0] r_y;
         logic             r_y_valid;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_y       <= '0;
               r_y_valid <= 1'b0;
            end else begin
               r_y_valid <= en;
               if (en) begin
                  r_y <= w_sel_data;
               end
            end
         end

         assign y       = r_y;
         assign y_valid = r_y_valid;
      end else begin : g_comb_out
         assign y       = w_sel_data;
         assign y_valid = en & ~rst;
      end
   endgenerate

endmodule

// File: tb/tb_mux_2to1.sv
// tb/tb_mux_2to1.sv - scoreboard bench for mux_2to1 (registered, saturating and combinational builds)
module tb_mux_2to1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Shared stimulus for the two registered WIDTH=1 builds (CNT_W=8 and CNT_W=2)
   logic       rst, en, a, b, sel;
   logic       y8, v8, y2, v2;
   logic [7:0] c8;
   logic [1:0] c2;

   // Combinational WIDTH=8 build
   logic       c_rst, c_en, c_sel;
   logic [7:0] c_a, c_b, c_y, c_cnt;
   logic       c_v;

   mux_2to1 #(.WIDTH(1), .REG_OUT(1), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .sel(sel),
      .y(y8), .y_valid(v8), .sel_changes(c8));

   mux_2to1 #(.WIDTH(1), .REG_OUT(1), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .sel(sel),
      .y(y2), .y_valid(v2), .sel_changes(c2));

   mux_2to1 #(.WIDTH(8), .REG_OUT(0), .CNT_W(8)) u_comb (
      .clk(clk), .rst(c_rst), .en(c_en), .a(c_a), .b(c_b), .sel(c_sel),
      .y(c_y), .y_valid(c_v), .sel_changes(c_cnt));

   typedef struct {
      string tag;
      logic  y;
      logic  v;
      int    c8;
      int    c2;
   } exp_t;

   exp_t sb[$];
   int checks   = 0;
   int failures = 0;

   logic m_y = 1'b0;
   logic m_v = 1'b0;
   logic m_last = 1'b0;
   int   m_c8 = 0;
   int   m_c2 = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic t_rst, input logic t_en,
                       input logic t_a, input logic t_b, input logic t_sel);
      exp_t e;
      exp_t got;
      @(negedge clk);
      rst = t_rst; en = t_en; a = t_a; b = t_b; sel = t_sel;
      if (t_rst) begin
         m_y = 1'b0; m_v = 1'b0; m_last = 1'b0; m_c8 = 0; m_c2 = 0;
      end else if (t_en) begin
         m_y = t_sel ? t_b : t_a;
         m_v = 1'b1;
         if (t_sel != m_last) begin
            if (m_c8 < 255) m_c8++;
            if (m_c2 < 3) m_c2++;
         end
         m_last = t_sel;
      end else begin
         m_v = 1'b0;
      end
      e.tag = tag; e.y = m_y; e.v = m_v; e.c8 = m_c8; e.c2 = m_c2;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'(0), 32'(1));
      end else begin
         got = sb.pop_front();
         check({got.tag, "_y"},      32'(y8), 32'(got.y));
         check({got.tag, "_valid"},  32'(v8), 32'(got.v));
         check({got.tag, "_cnt8"},   32'(c8), 32'(got.c8));
         check({got.tag, "_y_w2"},   32'(y2), 32'(got.y));
         check({got.tag, "_cnt2"},   32'(c2), 32'(got.c2));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0; sel = 1'b0;
      c_rst = 1'b1; c_en = 1'b0; c_sel = 1'b0; c_a = 8'h00; c_b = 8'h00;

      // Reset with en asserted and sel=1
      for (int i = 0; i < 2; i++) step("reset", 1, 1, 1, 0, 1);

      // Truth table
      step("tt0", 0, 1, 0, 1, 0);
      step("tt1", 0, 1, 0, 1, 1);
      step("tt2", 0, 1, 1, 0, 0);
      step("tt3", 0, 1, 1, 0, 1);

      // Hold while disabled
      step("hold_sel", 0, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) step("hold", 0, 0, 0, 1, 1);

      // Saturation: toggle from sel=1
      step("sat_rst", 1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) step("sat", 0, 1, 0, 1, logic'((i + 1) % 2));

      // Reset mid-operation with two changes recorded
      step("mid_rst0", 1, 0, 0, 0, 0);
      step("mid_a", 0, 1, 0, 1, 1);
      step("mid_b", 0, 1, 0, 1, 0);
      step("mid_rst", 1, 1, 1, 1, 1);
      step("mid_fresh", 0, 1, 0, 1, 1);

      // Random mix
      for (int i = 0; i < 40; i++) begin
         step("rand", logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 3) != 0),
              logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 1)));
      end

      // Combinational build
      @(negedge clk);
      c_rst = 1'b0; c_en = 1'b1; c_a = 8'h5A; c_b = 8'hC3; c_sel = 1'b0;
      #1;
      check("comb_sel0_y", 32'(c_y), 32'h5A);
      check("comb_sel0_valid", 32'(c_v), 32'(1));
      @(posedge clk);
      #1;
      check("comb_cnt_nochange", 32'(c_cnt), 32'(0));
      c_sel = 1'b1;
      #1;
      check("comb_sel1_y", 32'(c_y), 32'hC3);
      @(posedge clk);
      #1;
      check("comb_cnt_change", 32'(c_cnt), 32'(1));
      c_rst = 1'b1;
      #1;
      check("comb_rst_y", 32'(c_y), 32'hC3);
      check("comb_rst_valid", 32'(c_v), 32'(0));
      c_rst = 1'b0; c_en = 1'b0;
      #1;
      check("comb_dis_valid", 32'(c_v), 32'(0));

      check("sb_drained", 32'(sb.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
